// File: rtl/alu_sequencer_if.sv
// Bus bundle between the ALU sequencer and its environment: instruction
// handshake, external register loads, the external ALU and the result/status outputs.
interface alu_sequencer_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       load_en;
  logic [1:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic       alu_n;
  logic       alu_z;
  logic       flag_n;
  logic       flag_z;
  logic       done;
  logic [7:0] wb_data;
  logic       illegal;

  modport slave (
    input  instr_valid, instr, load_en, load_addr, load_data, alu_out, alu_n, alu_z,
    output instr_ready, alu_in1, alu_in2, alu_op, flag_n, flag_z, done, wb_data, illegal
  );

  modport master (
    output instr_valid, instr, load_en, load_addr, load_data, alu_out, alu_n, alu_z,
    input  instr_ready, alu_in1, alu_in2, alu_op, flag_n, flag_z, done, wb_data, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) that fetches two operands from a
// 4x8 register file, drives an external ALU and writes the result back to rx.
module alu_sequencer (
  input  logic         clock,
  input  logic         reset,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [2:0] OP_NONE = 3'b111;

  state_t     state;
  logic [7:0] regs [0:3];
  logic [7:0] ir;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] result_q;
  logic [2:0] alu_op_q;
  logic       ready_q;
  logic       done_q;
  logic       illegal_q;
  logic       flag_n_q;
  logic       flag_z_q;

  // Opcode fields of the captured instruction.
  logic [1:0] rx;
  logic [1:0] ry;
  assign rx = ir[7:6];
  assign ry = ir[5:4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      // NOTE: the register file is architecturally visible after reset, so
      // every entry is cleared here rather than left to power-up contents.
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      ir        <= 8'h00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      result_q  <= 8'h00;
      alu_op_q  <= OP_NONE;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; only the state that
      // raises them overrides, so no stale pulse can survive a transition.
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_en) regs[bus.load_addr] <= bus.load_data;
          if (bus.instr_valid && ready_q) begin
            ir        <= bus.instr;
            illegal_q <= (bus.instr[3:0] > 4'd4);
            ready_q   <= 1'b0;
            state     <= READ;
          end else begin
            ready_q <= 1'b1;
          end
        end
        READ: begin
          if (ir[3:0] > 4'd4) begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            a_q      <= regs[rx];
            b_q      <= regs[ry];
            alu_op_q <= ir[2:0];
            state    <= EXEC;
          end
        end
        EXEC: begin
          result_q <= bus.alu_out;
          flag_n_q <= bus.alu_n;
          flag_z_q <= bus.alu_z;
          alu_op_q <= OP_NONE;
          done_q   <= 1'b1;
          state    <= WB;
        end
        WB: begin
          regs[rx] <= result_q;
          ready_q  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.alu_in1     = a_q;
  assign bus.alu_in2     = b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.flag_n      = flag_n_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.done        = done_q;
  assign bus.wb_data     = result_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; models the external ALU and checks each
// scenario cycle by cycle, sampling on the falling clock edge.
module tb_alu_sequencer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_sequencer_if bus ();
  alu_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_r [0:3];

  // External ALU model.
  logic [7:0] alu_res;
  always_comb begin
    alu_res = 8'h00;
    case (bus.alu_op)
      3'b000: alu_res = bus.alu_in1 + bus.alu_in2;
      3'b001: alu_res = bus.alu_in1 - bus.alu_in2;
      3'b010: alu_res = bus.alu_in1 | bus.alu_in2;
      3'b011: alu_res = ~(bus.alu_in1 & bus.alu_in2);
      3'b100: alu_res = bus.alu_in2[2] ? (bus.alu_in1 << bus.alu_in2[1:0])
                                       : (bus.alu_in1 >> bus.alu_in2[1:0]);
      default: alu_res = 8'h00;
    endcase
  end
  assign bus.alu_out = alu_res;
  assign bus.alu_n   = alu_res[7];
  assign bus.alu_z   = (alu_res == 8'h00);

  always @(negedge clock) begin
    total++;
    if (bus.done && bus.illegal) begin
      bad++; $display("FAIL done_illegal_overlap got done=1 illegal=1 want not both");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic load_reg(input logic [1:0] addr, input logic [7:0] data);
    bus.load_en = 1'b1; bus.load_addr = addr; bus.load_data = data;
    @(negedge clock);
    bus.load_en = 1'b0;
    exp_r[addr] = data;
  endtask

  // Issues one legal instruction from IDLE and checks every cycle through WB.
  task automatic run_instr(input string name, input logic [7:0] ins, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [2:0] eop, input logic [7:0] ewb,
                           input logic en, input logic ez);
    logic [1:0] rx;
    rx = ins[7:6];
    total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL %s idle_ready got=%b want=1", name, bus.instr_ready); end
    bus.instr_valid = 1'b1; bus.instr = ins;
    @(negedge clock); bus.instr_valid = 1'b0;
    total++; if (bus.instr_ready !== 1'b0) begin bad++; $display("FAIL %s read_ready got=%b want=0", name, bus.instr_ready); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL %s read_illegal got=%b want=0", name, bus.illegal); end
    total++; if (bus.alu_op !== 3'b111) begin bad++; $display("FAIL %s read_alu_op got=%b want=111", name, bus.alu_op); end
    @(negedge clock);
    total++; if (bus.alu_op !== eop) begin bad++; $display("FAIL %s exec_alu_op got=%b want=%b", name, bus.alu_op, eop); end
    total++; if (bus.alu_in1 !== e1) begin bad++; $display("FAIL %s exec_in1 got=%h want=%h", name, bus.alu_in1, e1); end
    total++; if (bus.alu_in2 !== e2) begin bad++; $display("FAIL %s exec_in2 got=%h want=%h", name, bus.alu_in2, e2); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s exec_done got=%b want=0", name, bus.done); end
    @(negedge clock);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL %s wb_done got=%b want=1", name, bus.done); end
    total++; if (bus.wb_data !== ewb) begin bad++; $display("FAIL %s wb_data got=%h want=%h", name, bus.wb_data, ewb); end
    total++; if (bus.flag_n !== en) begin bad++; $display("FAIL %s flag_n got=%b want=%b", name, bus.flag_n, en); end
    total++; if (bus.flag_z !== ez) begin bad++; $display("FAIL %s flag_z got=%b want=%b", name, bus.flag_z, ez); end
    @(negedge clock);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s idle_done got=%b want=0", name, bus.done); end
    total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL %s ready_again got=%b want=1", name, bus.instr_ready); end
    exp_r[rx] = ewb;
    total++; if (dut.regs[rx] !== ewb) begin bad++; $display("FAIL %s reg_writeback got=%h want=%h", name, dut.regs[rx], ewb); end
  endtask

  task automatic check_reset_values(input string name);
    total++; if (bus.instr_ready !== 1'b0) begin bad++; $display("FAIL %s ready got=%b want=0", name, bus.instr_ready); end
    total++; if (bus.alu_op !== 3'b111) begin bad++; $display("FAIL %s alu_op got=%b want=111", name, bus.alu_op); end
    total++; if (bus.done !== 1'b0 || bus.illegal !== 1'b0) begin bad++; $display("FAIL %s pulses got done=%b illegal=%b want=0,0", name, bus.done, bus.illegal); end
    total++; if (bus.flag_n !== 1'b0 || bus.flag_z !== 1'b0) begin bad++; $display("FAIL %s flags got n=%b z=%b want=0,0", name, bus.flag_n, bus.flag_z); end
    total++; if (bus.alu_in1 !== 8'h00 || bus.alu_in2 !== 8'h00 || bus.wb_data !== 8'h00) begin
      bad++; $display("FAIL %s data got in1=%h in2=%h wb=%h want=00", name, bus.alu_in1, bus.alu_in2, bus.wb_data);
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (dut.regs[i] !== 8'h00) begin bad++; $display("FAIL %s reg%0d got=%h want=00", name, i, dut.regs[i]); end
      exp_r[i] = 8'h00;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = 8'h00;
    bus.load_en = 1'b0; bus.load_addr = 2'd0; bus.load_data = 8'h00;
    #1 reset = 1'b1;
    #1 check_reset_values("reset_async");
    @(negedge clock); @(negedge clock);
    check_reset_values("reset_held");
    reset = 1'b0;
    @(negedge clock);
    total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", bus.instr_ready); end
  endtask

  task automatic test_add();
    load_reg(2'd1, 8'h05);
    load_reg(2'd2, 8'h03);
    run_instr("add", 8'h60, 8'h05, 8'h03, 3'b000, 8'h08, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    run_instr("sub_self", 8'h51, 8'h08, 8'h08, 3'b001, 8'h00, 1'b0, 1'b1);
    run_instr("add_after_zero", 8'h60, 8'h00, 8'h03, 3'b000, 8'h03, 1'b0, 1'b0);
  endtask

  task automatic test_shift();
    load_reg(2'd0, 8'h81);
    load_reg(2'd3, 8'h05);
    run_instr("shift_left", 8'h34, 8'h81, 8'h05, 3'b100, 8'h02, 1'b0, 1'b0);
    load_reg(2'd3, 8'h01);
    run_instr("shift_right", 8'h34, 8'h02, 8'h01, 3'b100, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_nand_illegal();
    load_reg(2'd2, 8'h7F);
    run_instr("nand_self", 8'hA3, 8'h7F, 8'h7F, 3'b011, 8'h80, 1'b1, 1'b0);
    bus.instr_valid = 1'b1; bus.instr = 8'h0F;
    @(negedge clock); bus.instr_valid = 1'b0;
    total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL illegal_pulse got=%b want=1", bus.illegal); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL illegal_done got=%b want=0", bus.done); end
    @(negedge clock);
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL illegal_one_cycle got=%b want=0", bus.illegal); end
    total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready got=%b want=1", bus.instr_ready); end
    total++; if (bus.flag_n !== 1'b1) begin bad++; $display("FAIL illegal_flag_n got=%b want=1", bus.flag_n); end
    total++; if (dut.regs[0] !== exp_r[0]) begin bad++; $display("FAIL illegal_r0 got=%h want=%h", dut.regs[0], exp_r[0]); end
    run_instr("or", 8'h22, 8'h01, 8'h80, 3'b010, 8'h81, 1'b1, 1'b0);
  endtask

  // Load R3 together with the first handshake, then hold instr_valid high.
  task automatic test_back_to_back();
    bus.load_en = 1'b1; bus.load_addr = 2'd3; bus.load_data = 8'h10;
    bus.instr_valid = 1'b1; bus.instr = 8'hD0;
    exp_r[3] = 8'h10;
    @(negedge clock);
    bus.load_en = 1'b0; bus.instr = 8'hF0;
    total++; if (bus.instr_ready !== 1'b0) begin bad++; $display("FAIL b2b_read_ready got=%b want=0", bus.instr_ready); end
    @(negedge clock);
    total++; if (bus.alu_in1 !== 8'h10 || bus.alu_in2 !== 8'h03) begin
      bad++; $display("FAIL b2b_first_operands got=%h,%h want=10,03", bus.alu_in1, bus.alu_in2);
    end
    bus.load_en = 1'b1; bus.load_addr = 2'd0; bus.load_data = 8'hEE;
    @(negedge clock);
    bus.load_en = 1'b0;
    total++; if (bus.done !== 1'b1 || bus.wb_data !== 8'h13) begin
      bad++; $display("FAIL b2b_first_wb got done=%b data=%h want 1,13", bus.done, bus.wb_data);
    end
    @(negedge clock);
    total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_t4 got=%b want=1", bus.instr_ready); end
    @(negedge clock);
    bus.instr_valid = 1'b0;
    total++; if (bus.instr_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accepted got ready=%b want=0", bus.instr_ready); end
    @(negedge clock);
    total++; if (bus.alu_in1 !== 8'h13 || bus.alu_in2 !== 8'h13 || bus.alu_op !== 3'b000) begin
      bad++; $display("FAIL b2b_second_exec got=%h,%h op=%b want=13,13 op=000", bus.alu_in1, bus.alu_in2, bus.alu_op);
    end
    @(negedge clock);
    total++; if (bus.done !== 1'b1 || bus.wb_data !== 8'h26) begin
      bad++; $display("FAIL b2b_second_wb got done=%b data=%h want 1,26", bus.done, bus.wb_data);
    end
    @(negedge clock);
    exp_r[3] = 8'h26;
    total++; if (dut.regs[3] !== exp_r[3]) begin bad++; $display("FAIL b2b_r3 got=%h want=%h", dut.regs[3], exp_r[3]); end
    total++; if (dut.regs[0] !== exp_r[0]) begin bad++; $display("FAIL b2b_load_ignored_r0 got=%h want=%h", dut.regs[0], exp_r[0]); end
  endtask

  task automatic test_reset_mid();
    bus.instr_valid = 1'b1; bus.instr = 8'h60;
    @(negedge clock); bus.instr_valid = 1'b0;
    @(negedge clock);
    total++; if (bus.alu_op !== 3'b000) begin bad++; $display("FAIL midrst_in_exec got op=%b want=000", bus.alu_op); end
    #2 reset = 1'b1;
    #1 check_reset_values("midrst_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_no_done cycle%0d got=%b want=0", c, bus.done); end
    end
    reset = 1'b0;
    @(negedge clock);
    total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_ready got=%b want=1", bus.instr_ready); end
    run_instr("post_reset_add", 8'h60, 8'h00, 8'h00, 3'b000, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_nand_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
